// File: rtl/serial_twoscomp_deser.sv
// rtl/serial_twoscomp_deser.sv - LSB-first serial two's-complement deserializer
// Frames W serial bits into a held word behind valid/ready, with min-negative, overrun and framing flags.
module serial_twoscomp_deser #(
   parameter int W = 8
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         start_in,
   input  logic         bit_in,
   input  logic         ready_in,
   input  logic         clr_in,
   output logic [W-1:0] word_out,
   output logic         valid_out,
   output logic         minneg_out,
   output logic         busy_out,
   output logic         overrun_out,
   output logic         frame_err_out
);

   localparam int CW = $clog2(W);
   localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-2:0]  shift_q, shift_d;
   logic [W-1:0]  word_q, word_d;
   logic [W-1:0]  frame_word;
   logic          valid_q, valid_d;
   logic          minneg_q, minneg_d;
   logic          ovr_q, ovr_d;
   logic          ferr_q, ferr_d;
   logic          complete;
   logic          restart;
   logic          drop;

   // The last bit is never stored: it joins the word directly at completion.
   assign frame_word = {bit_in, shift_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      complete = 1'b0;
      restart  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_in) begin
               shift_d[0] = bit_in;
               cnt_d      = CW'(1);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (start_in) begin
               restart    = 1'b1;
               shift_d[0] = bit_in;
               cnt_d      = CW'(1);
            end else if (cnt_q == CW'(W - 1)) begin
               complete = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               for (int i = 1; i < W - 1; i++) begin
                  if (cnt_q == CW'(i)) begin
                     shift_d[i] = bit_in;
                  end
               end
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A consume in the completion cycle frees the register, so that case is not an overrun.
   always_comb begin
      word_d   = word_q;
      minneg_d = minneg_q;
      valid_d  = valid_q;
      drop     = 1'b0;
      if (complete) begin
         if (!valid_q || ready_in) begin
            word_d   = frame_word;
            minneg_d = (frame_word == MINNEG);
            valid_d  = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
      ovr_d  = drop | (ovr_q & ~clr_in);
      ferr_d = restart | (ferr_q & ~clr_in);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         word_q   <= '0;
         valid_q  <= 1'b0;
         minneg_q <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         word_q   <= word_d;
         valid_q  <= valid_d;
         minneg_q <= minneg_d;
         ovr_q    <= ovr_d;
         ferr_q   <= ferr_d;
      end
   end

   assign word_out      = word_q;
   assign valid_out     = valid_q;
   assign minneg_out    = minneg_q;
   assign busy_out      = (state_q == SHIFT);
   assign overrun_out   = ovr_q;
   assign frame_err_out = ferr_q;

endmodule

// File: tb/tb_serial_twoscomp_deser.sv
// tb/tb_serial_twoscomp_deser.sv - self-checking bench for serial_twoscomp_deser
// Directed test-plan steps followed by random streaming against a queue-based frame model.
module tb_serial_twoscomp_deser;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         bitv;
   logic         ready;
   logic         clr;
   logic [W-1:0] word_out;
   logic         valid_out;
   logic         minneg_out;
   logic         busy_out;
   logic         overrun_out;
   logic         frame_err_out;

   int total = 0;
   int bad   = 0;
   int busy_cnt;

   // Reference model state
   bit           mq[$];
   logic         in_frame;
   logic [W-1:0] m_word;
   logic         m_valid;
   logic         m_minneg;
   logic         m_ovr;
   logic         m_ferr;

   serial_twoscomp_deser #(.W(W)) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .start_in      (start),
      .bit_in        (bitv),
      .ready_in      (ready),
      .clr_in        (clr),
      .word_out      (word_out),
      .valid_out     (valid_out),
      .minneg_out    (minneg_out),
      .busy_out      (busy_out),
      .overrun_out   (overrun_out),
      .frame_err_out (frame_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic s, input logic b, input logic r,
                             input logic c, input logic rs);
      logic         done;
      logic         oset;
      logic         fset;
      logic [W-1:0] w;
      done = 1'b0;
      oset = 1'b0;
      fset = 1'b0;
      w    = '0;
      if (rs) begin
         mq.delete();
         in_frame = 1'b0;
         m_word   = '0;
         m_valid  = 1'b0;
         m_minneg = 1'b0;
         m_ovr    = 1'b0;
         m_ferr   = 1'b0;
      end else begin
         if (s) begin
            if (in_frame) fset = 1'b1;
            mq.delete();
            in_frame = 1'b1;
            mq.push_back(b);
         end else if (in_frame) begin
            mq.push_back(b);
         end
         if (in_frame && mq.size() == W) begin
            done = 1'b1;
            for (int i = 0; i < W; i++) w[i] = mq[i];
            mq.delete();
            in_frame = 1'b0;
         end
         if (done) begin
            if (!m_valid || r) begin
               m_word   = w;
               m_minneg = (w == W'(1 << (W - 1)));
               m_valid  = 1'b1;
            end else begin
               oset = 1'b1;
            end
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
         m_ovr  = oset | (m_ovr & ~c);
         m_ferr = fset | (m_ferr & ~c);
      end
   endtask

   task automatic cyc(input logic s, input logic b, input logic r, input logic c, input logic rs);
      start = s;
      bitv  = b;
      ready = r;
      clr   = c;
      rst   = rs;
      @(posedge clk);
      model_step(s, b, r, c, rs);
      #1;
      check("model_word",   32'(word_out),      32'(m_word));
      check("model_valid",  32'(valid_out),     32'(m_valid));
      check("model_minneg", 32'(minneg_out),    32'(m_minneg));
      check("model_busy",   32'(busy_out),      32'(in_frame));
      check("model_ovr",    32'(overrun_out),   32'(m_ovr));
      check("model_ferr",   32'(frame_err_out), 32'(m_ferr));
      if (busy_out) busy_cnt++;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic r, input logic rlast);
      for (int i = 0; i < W; i++) begin
         cyc(i == 0, w[i], (i == W - 1) ? rlast : r, 1'b0, 1'b0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_word"},  32'(word_out),      32'h0);
      check({tag, "_valid"}, 32'(valid_out),     32'h0);
      check({tag, "_mn"},    32'(minneg_out),    32'h0);
      check({tag, "_busy"},  32'(busy_out),      32'h0);
      check({tag, "_ovr"},   32'(overrun_out),   32'h0);
      check({tag, "_ferr"},  32'(frame_err_out), 32'h0);
   endtask

   initial begin
      logic s;
      logic rs;
      logic c;
      start    = 1'b0;
      bitv     = 1'b0;
      ready    = 1'b0;
      clr      = 1'b0;
      rst      = 1'b1;
      busy_cnt = 0;
      in_frame = 1'b0;
      m_word   = '0;
      m_valid  = 1'b0;
      m_minneg = 1'b0;
      m_ovr    = 1'b0;
      m_ferr   = 1'b0;

      // Reset then idle
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all_zero("reset");
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all_zero("idle");

      // Single word 0x5A
      busy_cnt = 0;
      send_word(8'h5A, 1'b1, 1'b1);
      check("single_valid", 32'(valid_out), 32'h1);
      check("single_word", 32'(word_out), 32'h5A);
      check("single_minneg", 32'(minneg_out), 32'h0);
      check("single_busy_cycles", 32'(busy_cnt), 32'd7);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("single_valid_drop", 32'(valid_out), 32'h0);
      check("single_word_keep", 32'(word_out), 32'h5A);

      // Most-negative then 0x7F back to back
      send_word(8'h80, 1'b1, 1'b1);
      check("mn_word", 32'(word_out), 32'h80);
      check("mn_flag", 32'(minneg_out), 32'h1);
      send_word(8'h7F, 1'b1, 1'b1);
      check("b2b_word", 32'(word_out), 32'h7F);
      check("b2b_minneg", 32'(minneg_out), 32'h0);
      check("b2b_valid", 32'(valid_out), 32'h1);
      check("b2b_ovr", 32'(overrun_out), 32'h0);
      check("b2b_ferr", 32'(frame_err_out), 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Overrun
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      check("ovr_word", 32'(word_out), 32'h11);
      check("ovr_flag", 32'(overrun_out), 32'h1);
      check("ovr_valid", 32'(valid_out), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr_hold_valid", 32'(valid_out), 32'h1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ovr_drain", 32'(valid_out), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_clear", 32'(overrun_out), 32'h0);

      // Same-cycle consume and complete
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b1);
      check("same_word", 32'(word_out), 32'h33);
      check("same_valid", 32'(valid_out), 32'h1);
      check("same_ovr", 32'(overrun_out), 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Restart mid-frame
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_word(8'hC3, 1'b1, 1'b1);
      check("restart_ferr", 32'(frame_err_out), 32'h1);
      check("restart_word", 32'(word_out), 32'hC3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("restart_clr", 32'(frame_err_out), 32'h0);

      // Reset during bit 5 while a word is held
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_all_zero("midrst");
      send_word(8'h01, 1'b1, 1'b1);
      check("post_rst_word", 32'(word_out), 32'h01);
      check("post_rst_valid", 32'(valid_out), 32'h1);

      // Random streaming against the model
      for (int n = 0; n < 2000; n++) begin
         s  = in_frame ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 2) == 0);
         rs = ($urandom_range(0, 250) == 0);
         c  = ($urandom_range(0, 40) == 0);
         cyc(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_twoscomp_deser.md
# serial_twoscomp_deser

Receive-side deserializer for the LSB-first serial two's-complement stream produced by the serial negation FSM. It frames W serial bits into a parallel word, holds it in an output register behind a valid/ready handshake, and flags the most-negative value (whose negation overflows). It also reports overrun and framing errors. It sits directly downstream of the serial converter's N_out and upstream of any parallel consumer.

## Interface
- W, 8, word width in bits; legal range 2..32
- clk_in  input  1  clock; all state changes on rising edge
- rst_in  input  1  reset, synchronous, active-high
- start_in  input  1  frame start; high in the cycle carrying bit 0 (LSB)
- bit_in  input  1  serial data, LSB first, one bit per cycle
- ready_in  input  1  consumer accepts word_out when high with valid_out
- clr_in  input  1  clears sticky error flags
- word_out  output  W  last completed word
- valid_out  output  1  word_out holds an unconsumed word
- minneg_out  output  1  word_out equals 1 followed by W-1 zeros (-2^(W-1)); qualified by valid_out
- busy_out  output  1  frame in progress (state SHIFT)
- overrun_out  output  1  sticky: completed word dropped because the output register was full
- frame_err_out  output  1  sticky: frame restarted before completion

## Operation
- Two states, IDLE and SHIFT, plus a bit counter cnt of width ceil(log2 W).
- IDLE: start_in=0 -> stay. start_in=1 -> shift_reg[0]=bit_in, cnt=1, go to SHIFT.
- SHIFT, start_in=0: shift_reg[cnt]=bit_in, cnt=cnt+1. If cnt==W-1 this cycle, the frame completes and the state returns to IDLE.
- SHIFT, start_in=1 (restart), at any cnt including W-1: the partial frame is discarded and frame_err_out is set. shift_reg[0]=bit_in, cnt=1, stay in SHIFT. No word is delivered.
- Frame completion: the completed word is {bit_in, shift_reg[W-2:0]}.
  - If valid_out=0, or valid_out=1 and ready_in=1 in the same cycle: word_out gets the completed word, minneg_out is computed from it, and valid_out=1.
  - If valid_out=1 and ready_in=0: the completed word is dropped, word_out and minneg_out are unchanged, and overrun_out is set.
- Handshake: when valid_out=1, ready_in=1 and no completion occurs that cycle, valid_out goes to 0. word_out keeps its value. ready_in is ignored while valid_out=0.
- Sticky flags: cleared by clr_in=1 or rst_in. If set and clear occur in the same cycle, set wins.
- busy_out = (state==SHIFT).

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Reset values: state IDLE, cnt 0, word_out 0, valid_out 0, minneg_out 0, busy_out 0, overrun_out 0, frame_err_out 0. rst_in takes priority over all other inputs.
- Reset mid-frame abandons the frame. A held word is lost.
- Start edge is cycle 0. Bits are sampled at edges 0..W-1, and valid_out rises after edge W-1 (latency W cycles from the start edge).
- Gapless streaming: start_in may be asserted in the cycle immediately after the last-bit cycle. Throughput is one word per W cycles.
- A word completing in the same cycle its predecessor is consumed is not an overrun.
- In the cycle after a completion with a drop, valid_out remains 1 with the old word.

## Test plan
- Reset then idle: rst_in=1 for 2 cycles, then start_in=0 for 10 cycles -> all outputs 0, busy_out 0.
- Single word, W=8: start_in with bits 0x5A LSB-first (0,1,0,1,1,0,1,0), ready_in=1 -> valid_out high for one cycle after the 8th bit, word_out=0x5A, minneg_out=0, busy_out high for 7 cycles.
- Most-negative value and back-to-back frames: send 0x80 then 0x7F with no gap, ready_in=1 -> word_out=0x80 with minneg_out=1, then exactly 8 cycles later word_out=0x7F with minneg_out=0. No errors flagged.
- Overrun: ready_in=0, send 0x11 then 0x22 -> word_out stays 0x11, overrun_out=1. Raise ready_in -> valid_out drops next cycle. clr_in -> overrun_out=0.
- Same-cycle consume and complete: hold 0x11 with ready_in=0; raise ready_in exactly in the last-bit cycle of 0x33 -> word_out=0x33, valid_out stays 1, overrun_out stays 0.
- Restart and mid-frame reset: assert start_in after 4 bits, then send a full 0xC3 -> frame_err_out=1, word_out=0xC3. Next, assert rst_in during bit 5 of a frame -> all outputs return to 0, and a following clean frame 0x01 is delivered correctly.
